// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the ID/EX pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STALL      = 2'd1,
        MEM_WAIT   = 2'd2,
        MEM_WAIT_S = 2'd3
    } pipe_state_t;

    localparam logic [1:0]  MEMTOREG_LOAD = 2'b01;
    localparam logic [31:0] NOP_INST      = 32'h00000013;

    // Control bundle order: {pc_en, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM}
    localparam logic [5:0] CTL_RUN    = 6'b110101;
    localparam logic [5:0] CTL_FREEZE = 6'b000000;
    localparam logic [5:0] CTL_FLUSH  = 6'b111111;
    localparam logic [5:0] CTL_BUBBLE = 6'b000111;

endpackage

// File: rtl/idex_hazard_cmp.sv
// Load-use hazard detect: a valid load in EX whose destination is read by the valid instruction in ID.
module idex_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1_addr_ID,
    input  logic [4:0] rs2_addr_ID,
    input  logic       rs1_used_ID,
    input  logic       rs2_used_ID,
    input  logic       valid_ID,
    input  logic [4:0] rd_addr_EX,
    input  logic [1:0] memtoreg_EX,
    input  logic       regwrite_EX,
    input  logic       valid_EX,
    output logic       hazard
);

    logic load_ex;
    logic src_match;

    assign load_ex   = valid_EX & regwrite_EX & (memtoreg_EX == MEMTOREG_LOAD) & (rd_addr_EX != 5'd0);
    assign src_match = (rs1_used_ID & (rs1_addr_ID == rd_addr_EX)) |
                       (rs2_used_ID & (rs2_addr_ID == rd_addr_EX));
    assign hazard    = valid_ID & load_ex & src_match;

endmodule

// File: rtl/idex_pipe_ctrl.sv
// Stage-register enable/bubble sequencing for PC, IF/ID, ID/EX and EX/MEM, with
// saturating debug counters for stall cycles and redirect flushes.
module idex_pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk_IDEX,
    input  logic             rst_IDEX,
    input  logic [4:0]       rs1_addr_ID,
    input  logic [4:0]       rs2_addr_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic             valid_ID,
    input  logic [4:0]       rd_addr_EX,
    input  logic [1:0]       memtoreg_EX,
    input  logic             regwrite_EX,
    input  logic             valid_EX,
    input  logic             redirect_EX,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             en_IFID,
    output logic             NOP_IFID,
    output logic             en_IDEX,
    output logic             NOP_IDEX,
    output logic             en_EXMEM,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] BUB_INIT = 2'(LU_BUBBLES - 1);

    pipe_state_t state, state_nxt;
    logic [1:0]  bub_cnt, bub_nxt;
    logic [5:0]  ctl;
    logic        flush_inc;
    logic        hazard;

    idex_hazard_cmp u_hazard_cmp (
        .rs1_addr_ID (rs1_addr_ID),
        .rs2_addr_ID (rs2_addr_ID),
        .rs1_used_ID (rs1_used_ID),
        .rs2_used_ID (rs2_used_ID),
        .valid_ID    (valid_ID),
        .rd_addr_EX  (rd_addr_EX),
        .memtoreg_EX (memtoreg_EX),
        .regwrite_EX (regwrite_EX),
        .valid_EX    (valid_EX),
        .hazard      (hazard)
    );

    // bub_cnt holds the bubbles still owed after the current cycle's bubble.
    always_comb begin
        state_nxt = state;
        bub_nxt   = bub_cnt;
        ctl       = CTL_RUN;
        flush_inc = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    ctl       = CTL_FREEZE;
                    state_nxt = MEM_WAIT;
                end else if (redirect_EX) begin
                    ctl       = CTL_FLUSH;
                    flush_inc = 1'b1;
                end else if (hazard) begin
                    ctl       = CTL_BUBBLE;
                    bub_nxt   = BUB_INIT;
                    state_nxt = (LU_BUBBLES > 1) ? STALL : RUN;
                end
            end
            STALL: begin
                if (mem_busy) begin
                    ctl       = CTL_FREEZE;
                    state_nxt = MEM_WAIT_S;
                end else if (redirect_EX) begin
                    ctl       = CTL_FLUSH;
                    flush_inc = 1'b1;
                    bub_nxt   = 2'd0;
                    state_nxt = RUN;
                end else begin
                    ctl     = CTL_BUBBLE;
                    bub_nxt = bub_cnt - 2'd1;
                    if (bub_cnt <= 2'd1) state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                ctl = CTL_FREEZE;
                if (!mem_busy) state_nxt = RUN;
            end
            MEM_WAIT_S: begin
                ctl = CTL_FREEZE;
                if (!mem_busy) state_nxt = STALL;
            end
            default: begin
                state_nxt = RUN;
                bub_nxt   = 2'd0;
            end
        endcase
        // Downstream registers only honour reset while enabled, so keep them open.
        if (rst_IDEX) begin
            ctl       = CTL_RUN;
            flush_inc = 1'b0;
        end
    end

    assign {pc_en, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM} = ctl;
    assign state_o = state;

    always_ff @(posedge clk_IDEX or posedge rst_IDEX) begin
        if (rst_IDEX) begin
            state     <= RUN;
            bub_cnt   <= 2'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bub_cnt <= bub_nxt;
            if (!ctl[5] && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_idex_pipe_ctrl.sv
// Bench for idex_pipe_ctrl: a LU_BUBBLES=1 instance and a LU_BUBBLES=3/CNT_W=4 instance share stimulus.
module tb_idex_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk_IDEX = 1'b0;
    logic       rst_IDEX = 1'b0;
    logic [4:0] rs1_addr_ID, rs2_addr_ID, rd_addr_EX;
    logic       rs1_used_ID, rs2_used_ID, valid_ID, regwrite_EX, valid_EX, redirect_EX, mem_busy;
    logic [1:0] memtoreg_EX;

    logic        pc_en_a, en_IFID_a, NOP_IFID_a, en_IDEX_a, NOP_IDEX_a, en_EXMEM_a;
    logic [1:0]  state_a;
    logic [15:0] stall_a, flush_a;
    logic        pc_en_b, en_IFID_b, NOP_IFID_b, en_IDEX_b, NOP_IDEX_b, en_EXMEM_b;
    logic [1:0]  state_b;
    logic [3:0]  stall_b, flush_b;

    always #5 clk_IDEX = ~clk_IDEX;

    idex_pipe_ctrl #(.LU_BUBBLES(1), .CNT_W(16)) u_a (
        .clk_IDEX(clk_IDEX), .rst_IDEX(rst_IDEX),
        .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .valid_ID(valid_ID),
        .rd_addr_EX(rd_addr_EX), .memtoreg_EX(memtoreg_EX), .regwrite_EX(regwrite_EX),
        .valid_EX(valid_EX), .redirect_EX(redirect_EX), .mem_busy(mem_busy),
        .pc_en(pc_en_a), .en_IFID(en_IFID_a), .NOP_IFID(NOP_IFID_a), .en_IDEX(en_IDEX_a),
        .NOP_IDEX(NOP_IDEX_a), .en_EXMEM(en_EXMEM_a), .state_o(state_a),
        .stall_cnt(stall_a), .flush_cnt(flush_a));

    idex_pipe_ctrl #(.LU_BUBBLES(3), .CNT_W(4)) u_b (
        .clk_IDEX(clk_IDEX), .rst_IDEX(rst_IDEX),
        .rs1_addr_ID(rs1_addr_ID), .rs2_addr_ID(rs2_addr_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .valid_ID(valid_ID),
        .rd_addr_EX(rd_addr_EX), .memtoreg_EX(memtoreg_EX), .regwrite_EX(regwrite_EX),
        .valid_EX(valid_EX), .redirect_EX(redirect_EX), .mem_busy(mem_busy),
        .pc_en(pc_en_b), .en_IFID(en_IFID_b), .NOP_IFID(NOP_IFID_b), .en_IDEX(en_IDEX_b),
        .NOP_IDEX(NOP_IDEX_b), .en_EXMEM(en_EXMEM_b), .state_o(state_b),
        .stall_cnt(stall_b), .flush_cnt(flush_b));

    logic [39:0] obs_all [2];
    logic [39:0] exp_all [2];
    logic [5:0]  ctl_a, ctl_b;
    assign ctl_a = {pc_en_a, en_IFID_a, NOP_IFID_a, en_IDEX_a, NOP_IDEX_a, en_EXMEM_a};
    assign ctl_b = {pc_en_b, en_IFID_b, NOP_IFID_b, en_IDEX_b, NOP_IDEX_b, en_EXMEM_b};
    assign obs_all[0] = {ctl_a, state_a, stall_a, flush_a};
    assign obs_all[1] = {ctl_b, state_b, 12'd0, stall_b, 12'd0, flush_b};

    int errors = 0;
    int checks = 0;

    // Reference model: bubbles still owed, whether MEM is holding the pipe, and the two counts.
    int m_pend [2], n_pend [2];
    bit m_wait [2], n_wait [2];
    int m_sc [2], n_sc [2], m_fc [2], n_fc [2];

    function automatic int lu_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 0; m_wait[k] = 1'b0; m_sc[k] = 0; m_fc[k] = 0;
        end
    endtask

    task automatic model_eval();
        bit          haz;
        logic [5:0]  ctl;
        pipe_state_t es;
        haz = valid_ID && valid_EX && regwrite_EX && memtoreg_EX == 2'b01 && rd_addr_EX != 5'd0 &&
              ((rs1_used_ID && rs1_addr_ID == rd_addr_EX) || (rs2_used_ID && rs2_addr_ID == rd_addr_EX));
        for (int k = 0; k < 2; k++) begin
            n_pend[k] = m_pend[k]; n_wait[k] = m_wait[k]; n_fc[k] = m_fc[k];
            if (m_wait[k]) begin
                ctl = 6'b000000;
                if (!mem_busy) n_wait[k] = 1'b0;
            end else if (mem_busy) begin
                ctl = 6'b000000;
                n_wait[k] = 1'b1;
            end else if (redirect_EX) begin
                ctl = 6'b111111;
                n_pend[k] = 0;
                if (m_fc[k] < cmax_of(k)) n_fc[k] = m_fc[k] + 1;
            end else if (m_pend[k] > 0) begin
                ctl = 6'b000111;
                n_pend[k] = m_pend[k] - 1;
            end else if (haz) begin
                ctl = 6'b000111;
                n_pend[k] = lu_of(k) - 1;
            end else begin
                ctl = 6'b110101;
            end
            n_sc[k] = (!ctl[5] && m_sc[k] < cmax_of(k)) ? m_sc[k] + 1 : m_sc[k];
            if (m_wait[k]) es = (m_pend[k] > 0) ? MEM_WAIT_S : MEM_WAIT;
            else           es = (m_pend[k] > 0) ? STALL : RUN;
            exp_all[k] = {ctl, es, 16'(m_sc[k]), 16'(m_fc[k])};
        end
    endtask

    task automatic settle();
        @(negedge clk_IDEX);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk_IDEX);
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = n_pend[k]; m_wait[k] = n_wait[k]; m_sc[k] = n_sc[k]; m_fc[k] = n_fc[k];
        end
        #1;
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic us1, input logic us2,
                         input logic vi, input logic [4:0] rd, input logic [1:0] mt, input logic rw,
                         input logic ve, input logic rdr, input logic bsy);
        rs1_addr_ID = a1; rs2_addr_ID = a2; rs1_used_ID = us1; rs2_used_ID = us2; valid_ID = vi;
        rd_addr_EX = rd; memtoreg_EX = mt; regwrite_EX = rw; valid_EX = ve;
        redirect_EX = rdr; mem_busy = bsy;
    endtask

    // lw x5 in EX, add x6,x5,x1 in ID
    task automatic drive_lw_add(input logic rdr, input logic bsy);
        drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b1, 5'd5, 2'b01, 1'b1, 1'b1, rdr, bsy);
    endtask

    task automatic drive_idle(input logic bsy);
        drive(5'd6, 5'd2, 1'b1, 1'b1, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0, bsy);
    endtask

    task automatic do_reset();
        drive_idle(1'b0);
        rst_IDEX = 1'b1;
        model_reset();
        @(posedge clk_IDEX);
        #1;
        rst_IDEX = 1'b0;
    endtask

    task automatic test_reset();
        drive_lw_add(1'b1, 1'b1);
        #1 rst_IDEX = 1'b1;
        #2;
        checks++;
        if (ctl_a !== 6'b110101 || ctl_b !== 6'b110101) begin
            errors++; $display("FAIL reset_ctl got a=%b b=%b want 110101", ctl_a, ctl_b);
        end
        @(posedge clk_IDEX); #1;
        checks++;
        if ({state_a, stall_a, flush_a} !== {RUN, 16'd0, 16'd0} || {state_b, stall_b, flush_b} !== {RUN, 8'd0}) begin
            errors++; $display("FAIL reset_regs got a=%h/%h/%h b=%h/%h/%h want 0", state_a, stall_a, flush_a, state_b, stall_b, flush_b);
        end
        rst_IDEX = 1'b0;
        model_reset();
    endtask

    task automatic test_load_use();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive_lw_add(1'b0, 1'b0); else drive_idle(1'b0);
            settle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_all[k] !== exp_all[k]) begin
                    errors++; $display("FAIL load_use inst%0d cyc%0d got %h want %h", k, c, obs_all[k], exp_all[k]);
                end
            end
            if (c == 0) begin
                checks++;
                if ({pc_en_a, en_IFID_a, NOP_IDEX_a} !== 3'b001) begin
                    errors++; $display("FAIL lu1_bubble got %b want 001", {pc_en_a, en_IFID_a, NOP_IDEX_a});
                end
            end
            if (c == 1) begin
                checks++;
                if (pc_en_a !== 1'b1 || stall_a !== 16'd1 || state_a !== RUN) begin
                    errors++; $display("FAIL lu1_resume got pc_en=%b stall=%0d state=%0d want 1/1/0", pc_en_a, stall_a, state_a);
                end
            end
            tick();
        end
    endtask

    task automatic test_no_hazard();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: drive(5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 5'd0, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
                1: drive(5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
                default: drive(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
            endcase
            settle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_all[k] !== exp_all[k]) begin
                    errors++; $display("FAIL no_hazard inst%0d case%0d got %h want %h", k, c, obs_all[k], exp_all[k]);
                end
            end
            checks++;
            if (pc_en_a !== 1'b1 || pc_en_b !== 1'b1) begin
                errors++; $display("FAIL no_hazard_pc case%0d got a=%b b=%b want 1", c, pc_en_a, pc_en_b);
            end
            tick();
        end
    endtask

    task automatic test_redirect_hazard();
        do_reset();
        for (int c = 0; c < 2; c++) begin
            if (c == 0) drive_lw_add(1'b1, 1'b0); else drive_idle(1'b0);
            settle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_all[k] !== exp_all[k]) begin
                    errors++; $display("FAIL redirect inst%0d cyc%0d got %h want %h", k, c, obs_all[k], exp_all[k]);
                end
            end
            if (c == 0) begin
                checks++;
                if (ctl_a !== 6'b111111 || ctl_b !== 6'b111111) begin
                    errors++; $display("FAIL redirect_ctl got a=%b b=%b want 111111", ctl_a, ctl_b);
                end
            end else begin
                checks++;
                if (flush_a !== 16'd1 || stall_a !== 16'd0 || flush_b !== 4'd1 || stall_b !== 4'd0) begin
                    errors++; $display("FAIL redirect_cnt got flush=%0d stall=%0d want 1/0", flush_a, stall_a);
                end
            end
            tick();
        end
    endtask

    task automatic test_lu3_busy();
        int zc = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c == 0) drive_lw_add(1'b0, 1'b0); else drive_idle(c == 1);
            settle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_all[k] !== exp_all[k]) begin
                    errors++; $display("FAIL lu3_busy inst%0d cyc%0d got %h want %h", k, c, obs_all[k], exp_all[k]);
                end
            end
            if (!pc_en_b) zc++;
            tick();
        end
        checks++;
        if (zc != 5 || stall_b !== 4'd5) begin
            errors++; $display("FAIL lu3_busy_total got cycles=%0d stall=%0d want 5/5", zc, stall_b);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive_lw_add(1'b0, 1'b0);
        settle();
        tick();
        drive_idle(1'b0);
        #2;
        checks++;
        if (state_b !== STALL) begin
            errors++; $display("FAIL pre_reset_state got %0d want %0d", state_b, STALL);
        end
        rst_IDEX = 1'b1;
        #1;
        checks++;
        if (ctl_b !== 6'b110101 || state_b !== RUN || stall_b !== 4'd0 || flush_b !== 4'd0 || stall_a !== 16'd0) begin
            errors++; $display("FAIL mid_stall_reset got ctl=%b state=%0d stall=%0d want 110101/0/0", ctl_b, state_b, stall_b);
        end
        model_reset();
        @(posedge clk_IDEX); #1;
        rst_IDEX = 1'b0;
    endtask

    task automatic test_flush_sat();
        do_reset();
        for (int c = 0; c < 21; c++) begin
            if (c < 20) drive_lw_add(1'b1, 1'b0); else drive_idle(1'b0);
            settle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_all[k] !== exp_all[k]) begin
                    errors++; $display("FAIL flush_sat inst%0d cyc%0d got %h want %h", k, c, obs_all[k], exp_all[k]);
                end
            end
            if (c == 20) begin
                checks++;
                if (flush_b !== 4'd15 || flush_a !== 16'd20) begin
                    errors++; $display("FAIL flush_saturate got b=%0d a=%0d want 15/20", flush_b, flush_a);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) != 0), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
            settle();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_all[k] !== exp_all[k]) begin
                    errors++; $display("FAIL random inst%0d cyc%0d got %h want %h", k, c, obs_all[k], exp_all[k]);
                end
            end
            tick();
        end
    endtask

    initial begin
        drive_idle(1'b0);
        model_reset();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect_hazard();
        test_lu3_busy();
        test_reset_mid_stall();
        test_flush_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
